// File: rtl/jump_redirect_unit_if.sv
// Decode-side bundle for the jump/branch redirect unit: instruction fields in,
// redirect / link / return-address-stack status out.
interface jump_redirect_unit_if #(
    parameter int DATA_W    = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic              valid_in;
    logic              stall;
    logic [5:0]        opcode;
    logic [5:0]        func;
    logic [4:0]        rs_addr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [15:0]       imm16;
    logic [25:0]       target26;

    logic              redirect_valid;
    logic [DATA_W-1:0] redirect_pc;
    logic              link_we;
    logic [4:0]        link_addr;
    logic [DATA_W-1:0] link_data;
    logic [DATA_W-1:0] ras_top;
    logic [CNT_W-1:0]  ras_count;
    logic              ras_mispredict;
    logic              ras_overflow;

    modport master (
        output valid_in, stall, opcode, func, rs_addr, pc, rs_data, rt_data, imm16, target26,
        input  redirect_valid, redirect_pc, link_we, link_addr, link_data,
               ras_top, ras_count, ras_mispredict, ras_overflow
    );

    modport slave (
        input  valid_in, stall, opcode, func, rs_addr, pc, rs_data, rt_data, imm16, target26,
        output redirect_valid, redirect_pc, link_we, link_addr, link_data,
               ras_top, ras_count, ras_mispredict, ras_overflow
    );
endinterface

// File: rtl/jump_redirect_unit.sv
// Resolves J/JAL/BEQ/BNE/JR/JALR in one registered stage, squashes the wrong-path
// slot after each redirect and tracks return addresses in a circular stack.
module jump_redirect_unit #(
    parameter int DATA_W    = 32,
    parameter int RAS_DEPTH = 4,
    parameter int LINK_REG  = 31
) (
    input  logic              clk,
    input  logic              reset,
    jump_redirect_unit_if.slave bus
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;
    localparam int PTR_W = $clog2(RAS_DEPTH);

    localparam logic [0:0] ST_ACCEPT = 1'b0;
    localparam logic [0:0] ST_SHADOW = 1'b1;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    localparam logic [4:0]       LINK_A = 5'(LINK_REG);
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(RAS_DEPTH);

    logic [0:0]        r_state;
    logic [DATA_W-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_vld_p1;
    logic              r_link_we_p1;
    logic              r_mispredict_p1;
    logic [DATA_W-1:0] r_redirect_pc_p1;
    logic [DATA_W-1:0] r_link_data_p1;
    logic [4:0]        r_link_addr_p1;

    logic w_is_j, w_is_jal, w_is_beq, w_is_bne, w_is_jr, w_is_jalr;
    logic w_accept, w_squash, w_eq, w_redirect, w_push, w_pop, w_pop_ok;
    logic w_empty, w_full, w_mispredict;
    logic [DATA_W-1:0] w_p4, w_jump_tgt, w_br_tgt, w_tgt, w_top;
    logic [PTR_W-1:0]  w_top_idx, w_wr_idx;

    // ---- stage p0: decode and target resolution ----
    assign w_is_j    = (bus.opcode == OP_J);
    assign w_is_jal  = (bus.opcode == OP_JAL);
    assign w_is_beq  = (bus.opcode == OP_BEQ);
    assign w_is_bne  = (bus.opcode == OP_BNE);
    assign w_is_jr   = (bus.opcode == OP_SPECIAL) && (bus.func == FN_JR);
    assign w_is_jalr = (bus.opcode == OP_SPECIAL) && (bus.func == FN_JALR);

    assign w_accept = bus.valid_in && !bus.stall && (r_state == ST_ACCEPT);
    assign w_squash = bus.valid_in && !bus.stall && (r_state == ST_SHADOW);

    assign w_p4       = bus.pc + DATA_W'(4);
    assign w_jump_tgt = {w_p4[DATA_W-1:28], bus.target26, 2'b00};
    assign w_br_tgt   = w_p4 + {{(DATA_W-18){bus.imm16[15]}}, bus.imm16, 2'b00};
    assign w_eq       = (bus.rs_data == bus.rt_data);

    assign w_redirect = w_is_j || w_is_jal || w_is_jr || w_is_jalr ||
                        (w_is_beq && w_eq) || (w_is_bne && !w_eq);

    always_comb begin
        w_tgt = bus.rs_data;
        if (w_is_j || w_is_jal)
            w_tgt = w_jump_tgt;
        else if (w_is_beq || w_is_bne)
            w_tgt = w_br_tgt;
    end

    // Return-address stack: r_wr_ptr is the next free slot, the top sits just below it.
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL);
    assign w_top_idx = r_wr_ptr - 1'b1;
    assign w_top     = r_ras[w_top_idx];

    assign w_push       = w_is_jal || w_is_jalr;
    assign w_pop        = (w_is_jr || w_is_jalr) && (bus.rs_addr == LINK_A);
    assign w_pop_ok     = w_pop && !w_empty;
    assign w_mispredict = w_pop && (w_empty || (w_top != bus.rs_data));
    // A JALR $ra replaces the popped slot in place instead of moving the pointer.
    assign w_wr_idx     = w_pop_ok ? w_top_idx : r_wr_ptr;

    always_ff @(posedge clk) begin
        if (w_accept && w_push)
            r_ras[w_wr_idx] <= w_p4;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_ACCEPT;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept && w_redirect)
                r_state <= ST_SHADOW;
            else if (w_squash)
                r_state <= ST_ACCEPT;

            if (w_accept) begin
                if (w_pop_ok && !w_push) begin
                    r_wr_ptr <= r_wr_ptr - 1'b1;
                    r_count  <= r_count - 1'b1;
                end else if (w_push && !w_pop_ok) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (w_full)
                        r_overflow <= 1'b1;
                    else
                        r_count <= r_count + 1'b1;
                end
            end
        end
    end

    // ---- stage p1: registered outputs ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p1         <= 1'b0;
            r_link_we_p1     <= 1'b0;
            r_mispredict_p1  <= 1'b0;
            r_redirect_pc_p1 <= '0;
            r_link_data_p1   <= '0;
            r_link_addr_p1   <= '0;
        end else begin
            r_vld_p1        <= w_accept && w_redirect;
            r_link_we_p1    <= w_accept && w_push;
            r_mispredict_p1 <= w_accept && w_mispredict;
            if (w_accept && w_redirect)
                r_redirect_pc_p1 <= w_tgt;
            if (w_accept && w_push) begin
                r_link_data_p1 <= w_p4;
                r_link_addr_p1 <= LINK_A;
            end
        end
    end

    assign bus.redirect_valid = r_vld_p1;
    assign bus.redirect_pc    = r_redirect_pc_p1;
    assign bus.link_we        = r_link_we_p1;
    assign bus.link_addr      = r_link_addr_p1;
    assign bus.link_data      = r_link_data_p1;
    assign bus.ras_top        = w_empty ? '0 : w_top;
    assign bus.ras_count      = r_count;
    assign bus.ras_mispredict = r_mispredict_p1;
    assign bus.ras_overflow   = r_overflow;
endmodule

// File: tb/tb_jump_redirect_unit.sv
// Directed bench for jump_redirect_unit: a sequential vector table followed by
// hand-written overflow, stall and reset sequences.
module tb_jump_redirect_unit;
    localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_R = 6'h00, OP_NOP = 6'h08;
    localparam logic [5:0] FN_JR = 6'h08, FN_JALR = 6'h09, FN_ADD = 6'h20;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    jump_redirect_unit_if #(.DATA_W(32), .RAS_DEPTH(4)) ifc ();

    jump_redirect_unit #(.DATA_W(32), .RAS_DEPTH(4), .LINK_REG(31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  ra;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic        e_rv;
        logic [31:0] e_rpc;
        logic        e_lwe;
        logic [31:0] e_ld;
        logic [2:0]  e_cnt;
        logic        e_mp;
        logic [31:0] e_top;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [5:0] op, logic [5:0] fn, logic [4:0] ra,
                                logic [31:0] pc, logic [31:0] rs, logic [31:0] rt,
                                logic [15:0] imm, logic [25:0] tgt, logic e_rv,
                                logic [31:0] e_rpc, logic e_lwe, logic [31:0] e_ld,
                                logic [2:0] e_cnt, logic e_mp, logic [31:0] e_top);
        vec_t r;
        r.v = v; r.op = op; r.fn = fn; r.ra = ra; r.pc = pc; r.rs = rs; r.rt = rt;
        r.imm = imm; r.tgt = tgt; r.e_rv = e_rv; r.e_rpc = e_rpc; r.e_lwe = e_lwe;
        r.e_ld = e_ld; r.e_cnt = e_cnt; r.e_mp = e_mp; r.e_top = e_top;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] ra, input logic [31:0] pc, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [15:0] imm, input logic [25:0] tgt);
        ifc.valid_in = v;   ifc.opcode  = op;  ifc.func    = fn;  ifc.rs_addr  = ra;
        ifc.pc       = pc;  ifc.rs_data = rs;  ifc.rt_data = rt;  ifc.imm16    = imm;
        ifc.target26 = tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop_squash(input string name);
        drive(1'b1, OP_NOP, 6'h0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0, 26'h0);
        tick();
        chk({name, " squash rv"}, 64'(ifc.redirect_valid), 64'd0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        ifc.stall = 1'b0;
        drive(1'b0, OP_NOP, 6'h0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0, 26'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset rv",  64'(ifc.redirect_valid), 64'd0);
        chk("reset rpc", 64'(ifc.redirect_pc),    64'd0);
        chk("reset cnt", 64'(ifc.ras_count),      64'd0);
        chk("reset top", 64'(ifc.ras_top),        64'd0);
        chk("reset ov",  64'(ifc.ras_overflow),   64'd0);
        reset = 1'b0;

        tbl.push_back(mk(1, OP_JAL, 0, 0, 32'h0040_0010, 0, 0, 16'h0, 26'h0000100, 1, 32'h400, 1, 32'h0040_0014, 1, 0, 32'h0040_0014));
        tbl.push_back(mk(1, OP_NOP, 0, 0, 32'h0040_0400, 0, 0, 16'h0, 26'h0, 0, 32'h400, 0, 32'h0040_0014, 1, 0, 32'h0040_0014));
        tbl.push_back(mk(1, OP_BEQ, 0, 0, 32'h100, 5, 5, 16'hFFFF, 26'h0, 1, 32'h100, 0, 32'h0040_0014, 1, 0, 32'h0040_0014));
        tbl.push_back(mk(1, OP_NOP, 0, 0, 32'h0, 0, 0, 16'h0, 26'h0, 0, 32'h100, 0, 32'h0040_0014, 1, 0, 32'h0040_0014));
        tbl.push_back(mk(1, OP_BEQ, 0, 0, 32'h100, 5, 6, 16'hFFFF, 26'h0, 0, 32'h100, 0, 32'h0040_0014, 1, 0, 32'h0040_0014));
        tbl.push_back(mk(1, OP_BNE, 0, 0, 32'h200, 5, 6, 16'h0010, 26'h0, 1, 32'h244, 0, 32'h0040_0014, 1, 0, 32'h0040_0014));
        tbl.push_back(mk(0, OP_NOP, 0, 0, 32'h0, 0, 0, 16'h0, 26'h0, 0, 32'h244, 0, 32'h0040_0014, 1, 0, 32'h0040_0014));
        tbl.push_back(mk(1, OP_NOP, 0, 0, 32'h0, 0, 0, 16'h0, 26'h0, 0, 32'h244, 0, 32'h0040_0014, 1, 0, 32'h0040_0014));
        tbl.push_back(mk(1, OP_R, FN_JR, 31, 32'h300, 32'h0040_0014, 0, 16'h0, 26'h0, 1, 32'h0040_0014, 0, 32'h0040_0014, 0, 0, 32'h0));
        tbl.push_back(mk(1, OP_NOP, 0, 0, 32'h0, 0, 0, 16'h0, 26'h0, 0, 32'h0040_0014, 0, 32'h0040_0014, 0, 0, 32'h0));
        tbl.push_back(mk(1, OP_J, 0, 0, 32'hFFFF_FFFC, 0, 0, 16'h0, 26'h0000010, 1, 32'h40, 0, 32'h0040_0014, 0, 0, 32'h0));
        tbl.push_back(mk(1, OP_NOP, 0, 0, 32'h0, 0, 0, 16'h0, 26'h0, 0, 32'h40, 0, 32'h0040_0014, 0, 0, 32'h0));
        tbl.push_back(mk(1, OP_R, FN_JR, 5, 32'h300, 32'h1234, 0, 16'h0, 26'h0, 1, 32'h1234, 0, 32'h0040_0014, 0, 0, 32'h0));
        tbl.push_back(mk(1, OP_NOP, 0, 0, 32'h0, 0, 0, 16'h0, 26'h0, 0, 32'h1234, 0, 32'h0040_0014, 0, 0, 32'h0));
        tbl.push_back(mk(1, OP_R, FN_JR, 31, 32'h300, 32'h500, 0, 16'h0, 26'h0, 1, 32'h500, 0, 32'h0040_0014, 0, 1, 32'h0));
        tbl.push_back(mk(1, OP_NOP, 0, 0, 32'h0, 0, 0, 16'h0, 26'h0, 0, 32'h500, 0, 32'h0040_0014, 0, 0, 32'h0));
        tbl.push_back(mk(1, OP_JAL, 0, 0, 32'h1000, 0, 0, 16'h0, 26'h0000200, 1, 32'h800, 1, 32'h1004, 1, 0, 32'h1004));
        tbl.push_back(mk(1, OP_NOP, 0, 0, 32'h0, 0, 0, 16'h0, 26'h0, 0, 32'h800, 0, 32'h1004, 1, 0, 32'h1004));
        tbl.push_back(mk(1, OP_R, FN_JR, 31, 32'h300, 32'h500, 0, 16'h0, 26'h0, 1, 32'h500, 0, 32'h1004, 0, 1, 32'h0));
        tbl.push_back(mk(1, OP_NOP, 0, 0, 32'h0, 0, 0, 16'h0, 26'h0, 0, 32'h500, 0, 32'h1004, 0, 0, 32'h0));
        tbl.push_back(mk(1, OP_R, FN_JALR, 4, 32'h1100, 32'h2000, 0, 16'h0, 26'h0, 1, 32'h2000, 1, 32'h1104, 1, 0, 32'h1104));
        tbl.push_back(mk(1, OP_NOP, 0, 0, 32'h0, 0, 0, 16'h0, 26'h0, 0, 32'h2000, 0, 32'h1104, 1, 0, 32'h1104));
        tbl.push_back(mk(1, OP_R, FN_JALR, 31, 32'h1200, 32'h1104, 0, 16'h0, 26'h0, 1, 32'h1104, 1, 32'h1204, 1, 0, 32'h1204));
        tbl.push_back(mk(1, OP_NOP, 0, 0, 32'h0, 0, 0, 16'h0, 26'h0, 0, 32'h1104, 0, 32'h1204, 1, 0, 32'h1204));
        tbl.push_back(mk(1, OP_R, FN_ADD, 31, 32'h1300, 32'h9999, 0, 16'h0, 26'h0, 0, 32'h1104, 0, 32'h1204, 1, 0, 32'h1204));
        tbl.push_back(mk(1, OP_R, FN_JR, 31, 32'h1400, 32'h1204, 0, 16'h0, 26'h0, 1, 32'h1204, 0, 32'h1204, 0, 0, 32'h0));
        tbl.push_back(mk(1, OP_NOP, 0, 0, 32'h0, 0, 0, 16'h0, 26'h0, 0, 32'h1204, 0, 32'h1204, 0, 0, 32'h0));

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].fn, tbl[i].ra, tbl[i].pc, tbl[i].rs,
                  tbl[i].rt, tbl[i].imm, tbl[i].tgt);
            tick();
            chk($sformatf("v%0d rv",  i), 64'(ifc.redirect_valid), 64'(tbl[i].e_rv));
            chk($sformatf("v%0d rpc", i), 64'(ifc.redirect_pc),    64'(tbl[i].e_rpc));
            chk($sformatf("v%0d lwe", i), 64'(ifc.link_we),        64'(tbl[i].e_lwe));
            chk($sformatf("v%0d ld",  i), 64'(ifc.link_data),      64'(tbl[i].e_ld));
            chk($sformatf("v%0d la",  i), 64'(ifc.link_addr),      64'd31);
            chk($sformatf("v%0d cnt", i), 64'(ifc.ras_count),      64'(tbl[i].e_cnt));
            chk($sformatf("v%0d mp",  i), 64'(ifc.ras_mispredict), 64'(tbl[i].e_mp));
            chk($sformatf("v%0d top", i), 64'(ifc.ras_top),        64'(tbl[i].e_top));
            chk($sformatf("v%0d ov",  i), 64'(ifc.ras_overflow),   64'd0);
        end

        // Five calls into a 4-deep stack, then unwind past empty.
        for (int k = 1; k <= 5; k++) begin
            logic [31:0] pc_k;
            pc_k = 32'h1000 * (k + 1);
            drive(1'b1, OP_JAL, 6'h0, 5'd0, pc_k, 32'h0, 32'h0, 16'h0, 26'h0000040);
            tick();
            chk($sformatf("ovf jal%0d rv", k),  64'(ifc.redirect_valid), 64'd1);
            chk($sformatf("ovf jal%0d cnt", k), 64'(ifc.ras_count),      64'((k > 4) ? 4 : k));
            chk($sformatf("ovf jal%0d top", k), 64'(ifc.ras_top),        64'(pc_k + 32'd4));
            chk($sformatf("ovf jal%0d ov", k),  64'(ifc.ras_overflow),   64'(k == 5));
            nop_squash($sformatf("ovf jal%0d", k));
        end
        for (int k = 0; k < 5; k++) begin
            logic [31:0] ret;
            ret = 32'h6004 - 32'h1000 * k;
            drive(1'b1, OP_R, FN_JR, 5'd31, 32'h8800, ret, 32'h0, 16'h0, 26'h0);
            tick();
            chk($sformatf("pop%0d rpc", k), 64'(ifc.redirect_pc),    64'(ret));
            chk($sformatf("pop%0d mp", k),  64'(ifc.ras_mispredict), 64'(k == 4));
            chk($sformatf("pop%0d cnt", k), 64'(ifc.ras_count),      64'((k == 4) ? 0 : 3 - k));
            nop_squash($sformatf("pop%0d", k));
        end
        chk("ovf sticky", 64'(ifc.ras_overflow), 64'd1);

        // Stall holds a presented JR, then the release accepts it.
        ifc.stall = 1'b1;
        drive(1'b1, OP_R, FN_JR, 5'd2, 32'h9000, 32'hABC0, 32'h0, 16'h0, 26'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall%0d rv", k),  64'(ifc.redirect_valid), 64'd0);
            chk($sformatf("stall%0d rpc", k), 64'(ifc.redirect_pc),    64'h2004);
        end
        ifc.stall = 1'b0;
        tick();
        chk("stall rel rv",  64'(ifc.redirect_valid), 64'd1);
        chk("stall rel rpc", 64'(ifc.redirect_pc),    64'hABC0);
        ifc.stall = 1'b1;
        drive(1'b1, OP_NOP, 6'h0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0, 26'h0);
        tick();
        chk("stall shadow rv", 64'(ifc.redirect_valid), 64'd0);
        ifc.stall = 1'b0;
        nop_squash("stall shadow");
        drive(1'b1, OP_BEQ, 6'h0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0001, 26'h0);
        tick();
        chk("post shadow rv",  64'(ifc.redirect_valid), 64'd1);
        chk("post shadow rpc", 64'(ifc.redirect_pc),    64'h8);

        // Reset while in the shadow slot with two stacked returns.
        nop_squash("pre rst");
        drive(1'b1, OP_JAL, 6'h0, 5'd0, 32'h7000, 32'h0, 32'h0, 16'h0, 26'h0);
        tick();
        nop_squash("pre rst jal1");
        drive(1'b1, OP_JAL, 6'h0, 5'd0, 32'h8000, 32'h0, 32'h0, 16'h0, 26'h0);
        tick();
        chk("pre rst cnt", 64'(ifc.ras_count), 64'd2);
        drive(1'b0, OP_NOP, 6'h0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0, 26'h0);
        #2 reset = 1'b1;
        #1;
        chk("rst rv",  64'(ifc.redirect_valid), 64'd0);
        chk("rst rpc", 64'(ifc.redirect_pc),    64'd0);
        chk("rst lwe", 64'(ifc.link_we),        64'd0);
        chk("rst ld",  64'(ifc.link_data),      64'd0);
        chk("rst la",  64'(ifc.link_addr),      64'd0);
        chk("rst cnt", 64'(ifc.ras_count),      64'd0);
        chk("rst top", 64'(ifc.ras_top),        64'd0);
        chk("rst ov",  64'(ifc.ras_overflow),   64'd0);
        #2 reset = 1'b0;
        drive(1'b1, OP_J, 6'h0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0, 26'h0000004);
        tick();
        chk("post rst rv",  64'(ifc.redirect_valid), 64'd1);
        chk("post rst rpc", 64'(ifc.redirect_pc),    64'h10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
